// File: rtl/quad_carrier_nco.sv
`default_nettype none
// ============================================================================
// Module   : quad_carrier_nco
// Purpose  : Quadrature carrier NCO with a phase accumulator and a quarter-wave
//            sine table expanded by quadrant symmetry into cos/sin outputs.
// Revision : 1.0 - initial release
// ============================================================================
module quad_carrier_nco #(
    parameter int ACC_W  = 16,
    parameter int LUT_AW = 4,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] fcw_in,
    input  logic             fcw_we,
    input  logic             phase_clr,
    input  logic             conj,
    output logic [OUT_W-1:0] cos_out,
    output logic [OUT_W-1:0] sin_out,
    output logic             out_valid
);

    localparam int c_pw   = LUT_AW + 2;
    localparam int c_iw   = LUT_AW + 1;
    localparam int c_q    = 2 ** LUT_AW;
    localparam int c_amp  = (2 ** (OUT_W - 1)) - 1;

    localparam logic [ACC_W-1:0] c_fcw_rst = ACC_W'(1) << (ACC_W - 2);
    localparam logic [c_iw-1:0]  c_q_idx   = c_iw'(c_q);

    // Elaboration-time sine over 0..pi/2 (Taylor series), rounded half away
    // from zero; entries are non-negative so +0.5 then truncate suffices.
    function automatic int quarter_sine(input int k);
        real x;
        real term;
        real sum;
        x    = 1.5707963267948966 * real'(k) / real'(c_q);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(real'(c_amp) * sum + 0.5);
    endfunction

    logic [OUT_W-1:0] w_lut [0:c_q];

    for (genvar k = 0; k <= c_q; k++) begin : g_lut
        localparam logic [OUT_W-1:0] c_entry = OUT_W'(quarter_sine(k));
        assign w_lut[k] = c_entry;
    end

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_fcw;
    logic [c_pw-1:0]  r_p;
    logic             r_conj;
    logic             r_v1;

    // Phase accumulator and frequency register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_fcw <= c_fcw_rst;
        end else begin
            if (fcw_we) begin
                r_fcw <= fcw_in;
            end
            if (phase_clr) begin
                r_acc <= '0;
            end else if (en) begin
                r_acc <= r_acc + r_fcw;
            end
        end
    end

    // Stage 1 samples the pre-update accumulator, so a clear on the same edge
    // still yields the old phase for this sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p    <= '0;
            r_conj <= 1'b0;
            r_v1   <= 1'b0;
        end else begin
            r_v1 <= en;
            if (en) begin
                r_p    <= r_acc[ACC_W-1 -: c_pw];
                r_conj <= conj;
            end
        end
    end

    logic [c_iw-1:0]  w_idx_f;
    logic [c_iw-1:0]  w_idx_m;
    logic [OUT_W-1:0] w_fine;
    logic [OUT_W-1:0] w_mirr;
    logic [OUT_W-1:0] w_cos;
    logic [OUT_W-1:0] w_sin;
    logic [OUT_W-1:0] w_sin_o;

    assign w_idx_f = {1'b0, r_p[LUT_AW-1:0]};
    assign w_idx_m = c_q_idx - w_idx_f;
    assign w_fine  = w_lut[w_idx_f];
    assign w_mirr  = w_lut[w_idx_m];

    always_comb begin
        w_cos = w_mirr;
        w_sin = w_fine;
        case (r_p[c_pw-1 -: 2])
            2'd0: begin
                w_cos = w_mirr;
                w_sin = w_fine;
            end
            2'd1: begin
                w_cos = -w_fine;
                w_sin = w_mirr;
            end
            2'd2: begin
                w_cos = -w_mirr;
                w_sin = -w_fine;
            end
            default: begin
                w_cos = w_fine;
                w_sin = -w_mirr;
            end
        endcase
        w_sin_o = r_conj ? -w_sin : w_sin;
    end

    // Stage 2 output register; values hold whenever no sample is presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_out   <= '0;
            sin_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_v1;
            if (r_v1) begin
                cos_out <= w_cos;
                sin_out <= w_sin_o;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_carrier_nco.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_carrier_nco
// Purpose  : Scoreboard bench for quad_carrier_nco with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_carrier_nco;

    typedef struct {
        logic v;
        int   c;
        int   s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] fcw_in = '0;
    logic        fcw_we = 1'b0;
    logic        phase_clr = 1'b0;
    logic        conj = 1'b0;
    logic [7:0]  cos_out;
    logic [7:0]  sin_out;
    logic        out_valid;
    logic [1:0]  cos2;
    logic [1:0]  sin2;
    logic        valid2;

    int   total = 0;
    int   bad = 0;
    int   held_c = 0;
    int   held_s = 0;
    exp_t q[$];
    exp_t mon_x;

    // 16-point carrier values (angle = 22.5 deg * index), A = 127
    int cos16 [16] = '{127, 117, 90, 49, 0, -49, -90, -117,
                       -127, -117, -90, -49, 0, 49, 90, 117};
    int sin16 [16] = '{0, 49, 90, 117, 127, 117, 90, 49,
                       0, -49, -90, -117, -127, -117, -90, -49};
    logic [1:0] c2_tab [4] = '{2'b01, 2'b00, 2'b11, 2'b00};
    logic [1:0] s2_tab [4] = '{2'b00, 2'b01, 2'b00, 2'b11};

    always #5 clk = ~clk;

    quad_carrier_nco #(.ACC_W(16), .LUT_AW(4), .OUT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fcw_in    (fcw_in),
        .fcw_we    (fcw_we),
        .phase_clr (phase_clr),
        .conj      (conj),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .out_valid (out_valid)
    );

    quad_carrier_nco #(.ACC_W(16), .LUT_AW(4), .OUT_W(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (1'b1),
        .fcw_in    (16'h0000),
        .fcw_we    (1'b0),
        .phase_clr (1'b0),
        .conj      (1'b0),
        .cos_out   (cos2),
        .sin_out   (sin2),
        .out_valid (valid2)
    );

    // Monitor: the entry pushed for edge k-1 is due after edge k
    always begin
        @(posedge clk);
        #1;
        if (rst_n && q.size() >= 2) begin
            mon_x = q.pop_front();
            total++;
            if ({out_valid, cos_out, sin_out} !== {mon_x.v, 8'(mon_x.c), 8'(mon_x.s)}) begin
                bad++;
                $display("FAIL sample t=%0t: got v=%0b cos=%0d sin=%0d, want v=%0b cos=%0d sin=%0d",
                         $time, out_valid, $signed(cos_out), $signed(sin_out),
                         mon_x.v, mon_x.c, mon_x.s);
            end
        end
    end

    // Narrow instance: en held high from the first reset release
    initial begin
        @(posedge rst_n);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (i == 0) begin
                if (valid2 !== 1'b0) begin
                    bad++;
                    $display("FAIL w2_first_valid: got %0b want 0", valid2);
                end
            end else if ({valid2, cos2, sin2} !== {1'b1, c2_tab[(i-1)%4], s2_tab[(i-1)%4]}) begin
                bad++;
                $display("FAIL w2_sample[%0d]: got v=%0b cos=%b sin=%b want v=1 cos=%b sin=%b",
                         i, valid2, cos2, sin2, c2_tab[(i-1)%4], s2_tab[(i-1)%4]);
            end
        end
    end

    task automatic drive(input logic e, input logic we, input logic [15:0] fi,
                         input logic clr, input logic cj, input int ec, input int es);
        exp_t x;
        @(negedge clk);
        en        = e;
        fcw_we    = we;
        fcw_in    = fi;
        phase_clr = clr;
        conj      = cj;
        if (e) begin
            held_c = ec;
            held_s = es;
        end
        x.v = e;
        x.c = held_c;
        x.s = held_s;
        q.push_back(x);
    endtask

    task automatic pos16(input logic we, input logic [15:0] fi, input logic clr,
                         input logic cj, input int pos);
        drive(1'b1, we, fi, clr, cj, cos16[pos], cj ? -sin16[pos] : sin16[pos]);
    endtask

    task automatic idle(input logic clr);
        drive(1'b0, 1'b0, 16'h0000, clr, 1'b0, 0, 0);
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({out_valid, cos_out, sin_out} !== 17'd0) begin
            bad++;
            $display("FAIL %s: got v=%0b cos=%0d sin=%0d want all zero",
                     name, out_valid, $signed(cos_out), $signed(sin_out));
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_zero("reset_state");
        repeat (2) @(negedge clk);
        check_zero("reset_hold");
        rst_n = 1'b1;

        // fs/4 default carrier
        for (int i = 0; i < 8; i++) pos16(1'b0, 16'h0000, 1'b0, 1'b0, (4 * i) % 16);

        // New fcw takes effect one edge after the write
        pos16(1'b1, 16'h1000, 1'b0, 1'b0, 0);
        for (int i = 4; i <= 8; i++) pos16(1'b0, 16'h0000, 1'b0, 1'b0, i);

        // Gap in en: outputs freeze, phase continues where it left off
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 9);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 10);
        idle(1'b0);
        idle(1'b0);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 11);

        // Clear with fcw write: sample uses pre-clear phase, then fine steps
        pos16(1'b1, 16'h0200, 1'b1, 1'b0, 12);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 127, 0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 127, 0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 126, 12);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 126, 12);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 125, 25);
        drive(1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 125, 25);
        for (int i = 0; i < 4; i++) pos16(1'b0, 16'h0000, 1'b0, 1'b0, i);

        // Spectral inversion
        pos16(1'b1, 16'h4000, 1'b1, 1'b0, 4);
        for (int i = 0; i < 4; i++) pos16(1'b0, 16'h0000, 1'b0, 1'b1, 4 * i);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 0);

        // Zero fcw holds phase; fcw above half-scale wraps backwards
        pos16(1'b1, 16'h0000, 1'b0, 1'b0, 4);
        for (int i = 0; i < 3; i++) pos16(1'b0, 16'h0000, 1'b0, 1'b0, 8);
        pos16(1'b1, 16'hC000, 1'b0, 1'b0, 8);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 8);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 4);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 0);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 12);

        // Clear while idle still zeroes the phase
        idle(1'b1);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 0);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 12);
        idle(1'b0);
        idle(1'b0);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 8);
        pos16(1'b0, 16'h0000, 1'b0, 1'b0, 4);

        // Mid-stream reset
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        held_c = 0;
        held_s = 0;
        en = 1'b0;
        fcw_we = 1'b0;
        phase_clr = 1'b0;
        conj = 1'b0;
        #1 check_zero("midreset_async");
        repeat (2) @(negedge clk);
        check_zero("midreset_hold");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) pos16(1'b0, 16'h0000, 1'b0, 1'b0, 4 * i);
        idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
